// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: steps fetch/decode/execute/memory/write-back, one state per cycle.
// Optional performance counters (CYC_CNT, RET_CNT) are enabled by defining CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
    parameter int unsigned OP_W   = 6,
    parameter int unsigned ALUC_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [OP_W-1:0]   Op,
    input  logic [OP_W-1:0]   Funct,
    input  logic              Zero,
    input  logic              MEM_RDY,
    output logic              PC_WE,
    output logic [1:0]        PC_SRC,
    output logic              IORD,
    output logic              MEM_RE,
    output logic              MEM_WE,
    output logic              IR_WE,
    output logic              REG_WE,
    output logic              REG_DST,
    output logic              MEM_TO_REG,
    output logic              ALU_SRC_A,
    output logic [1:0]        ALU_SRC_B,
    output logic [ALUC_W-1:0] ALU_CTL,
    output logic              ILL_OP,
    output logic [3:0]        STATE
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       CYC_CNT,
    output logic [31:0]       RET_CNT
`endif
);

    localparam logic [OP_W-1:0] OP_R_FORM = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_LW     = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW     = OP_W'(6'h2B);
    localparam logic [OP_W-1:0] OP_BEQ    = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_ADDI   = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_J      = OP_W'(6'h02);

    localparam logic [OP_W-1:0] FN_ADD = OP_W'(6'h20);
    localparam logic [OP_W-1:0] FN_SUB = OP_W'(6'h22);
    localparam logic [OP_W-1:0] FN_AND = OP_W'(6'h24);
    localparam logic [OP_W-1:0] FN_OR  = OP_W'(6'h25);
    localparam logic [OP_W-1:0] FN_SLT = OP_W'(6'h2A);

    localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(3'b010);
    localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(3'b110);
    localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(3'b000);
    localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(3'b001);
    localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(3'b111);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    state_t state, state_nxt;
    logic   pc_we_c, mem_re_c, mem_we_c, ir_we_c, reg_we_c, ill_op_c;
    logic   retire_c;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_FETCH;
        else      state <= state_nxt;
    end

    // Next-state and datapath control decode
    always_comb begin
        state_nxt  = S_FETCH;
        pc_we_c    = 1'b0;
        PC_SRC     = 2'b00;
        IORD       = 1'b0;
        mem_re_c   = 1'b0;
        mem_we_c   = 1'b0;
        ir_we_c    = 1'b0;
        reg_we_c   = 1'b0;
        REG_DST    = 1'b0;
        MEM_TO_REG = 1'b0;
        ALU_SRC_A  = 1'b0;
        ALU_SRC_B  = 2'b00;
        ALU_CTL    = ALUC_W'(0);
        ill_op_c   = 1'b0;
        retire_c   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_re_c  = 1'b1;
                ALU_SRC_B = 2'b01;
                ALU_CTL   = ALU_ADD;
                if (MEM_RDY) begin
                    ir_we_c   = 1'b1;
                    pc_we_c   = 1'b1;
                    state_nxt = S_DECODE;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_DECODE: begin
                ALU_SRC_B = 2'b11;
                ALU_CTL   = ALU_ADD;
                case (Op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R_FORM:    state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALU_SRC_A = 1'b1;
                ALU_SRC_B = 2'b10;
                ALU_CTL   = ALU_ADD;
                state_nxt = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_re_c  = 1'b1;
                IORD      = 1'b1;
                state_nxt = MEM_RDY ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_we_c   = 1'b1;
                MEM_TO_REG = 1'b1;
                retire_c   = 1'b1;
            end
            S_MEMWR: begin
                mem_we_c  = 1'b1;
                IORD      = 1'b1;
                retire_c  = MEM_RDY;
                state_nxt = MEM_RDY ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALU_SRC_A = 1'b1;
                state_nxt = S_ALUWB;
                case (Funct)
                    FN_ADD:  ALU_CTL = ALU_ADD;
                    FN_SUB:  ALU_CTL = ALU_SUB;
                    FN_AND:  ALU_CTL = ALU_AND;
                    FN_OR:   ALU_CTL = ALU_OR;
                    FN_SLT:  ALU_CTL = ALU_SLT;
                    default: state_nxt = S_ILLEGAL;
                endcase
            end
            S_ALUWB: begin
                reg_we_c = 1'b1;
                REG_DST  = 1'b1;
                retire_c = 1'b1;
            end
            S_BRANCH: begin
                ALU_SRC_A = 1'b1;
                ALU_CTL   = ALU_SUB;
                pc_we_c   = Zero;
                PC_SRC    = 2'b01;
                retire_c  = 1'b1;
            end
            S_ADDIEX: begin
                ALU_SRC_A = 1'b1;
                ALU_SRC_B = 2'b10;
                ALU_CTL   = ALU_ADD;
                state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_we_c = 1'b1;
                retire_c = 1'b1;
            end
            S_JUMP: begin
                pc_we_c  = 1'b1;
                PC_SRC   = 2'b10;
                retire_c = 1'b1;
            end
            S_ILLEGAL: ill_op_c = 1'b1;
            default:   state_nxt = S_FETCH;
        endcase
    end

    // Enables and requests are squelched for as long as reset is held
    assign PC_WE  = pc_we_c  & RST;
    assign MEM_RE = mem_re_c & RST;
    assign MEM_WE = mem_we_c & RST;
    assign IR_WE  = ir_we_c  & RST;
    assign REG_WE = reg_we_c & RST;
    assign ILL_OP = ill_op_c & RST;
    assign STATE  = state;

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            CYC_CNT <= 32'd0;
            RET_CNT <= 32'd0;
        end else begin
            CYC_CNT <= CYC_CNT + 32'd1;
            if (retire_c) RET_CNT <= RET_CNT + 32'd1;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire_c;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes hand-computed per-cycle output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] Op, Funct;
    logic       Zero, MEM_RDY;
    logic       PC_WE, IORD, MEM_RE, MEM_WE, IR_WE, REG_WE, REG_DST, MEM_TO_REG, ALU_SRC_A, ILL_OP;
    logic [1:0] PC_SRC, ALU_SRC_B;
    logic [2:0] ALU_CTL;
    logic [3:0] STATE;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] CYC_CNT, RET_CNT;
`endif

    multicycle_ctrl #(.OP_W(6), .ALUC_W(3)) dut (
        .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero), .MEM_RDY(MEM_RDY),
        .PC_WE(PC_WE), .PC_SRC(PC_SRC), .IORD(IORD), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
        .IR_WE(IR_WE), .REG_WE(REG_WE), .REG_DST(REG_DST), .MEM_TO_REG(MEM_TO_REG),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_CTL(ALU_CTL), .ILL_OP(ILL_OP),
        .STATE(STATE)
`ifdef CTRL_PERF_CNT_EN
        , .CYC_CNT(CYC_CNT), .RET_CNT(RET_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Vector layout: {STATE, PC_WE, PC_SRC, IORD, MEM_RE, MEM_WE, IR_WE, REG_WE, REG_DST, MEM_TO_REG, ALU_SRC_A, ALU_SRC_B, ALU_CTL, ILL_OP}
    //                                        st     pcwe  pcsrc  iord  mre   mwe   irwe  rwe   rdst  m2r   asa   asb    aluc    ill
    localparam logic [20:0] E_RST    = {4'd0,  1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 1'b0};
    localparam logic [20:0] E_FW     = {4'd0,  1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 1'b0};
    localparam logic [20:0] E_FR     = {4'd0,  1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 1'b0};
    localparam logic [20:0] E_DEC    = {4'd1,  1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b010, 1'b0};
    localparam logic [20:0] E_MADR   = {4'd2,  1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b010, 1'b0};
    localparam logic [20:0] E_MRD    = {4'd3,  1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};
    localparam logic [20:0] E_MWB    = {4'd4,  1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0};
    localparam logic [20:0] E_MWR    = {4'd5,  1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};
    localparam logic [20:0] E_EXADD  = {4'd6,  1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 1'b0};
    localparam logic [20:0] E_EXBAD  = {4'd6,  1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0};
    localparam logic [20:0] E_AWB    = {4'd7,  1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};
    localparam logic [20:0] E_BRZ1   = {4'd8,  1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110, 1'b0};
    localparam logic [20:0] E_BRZ0   = {4'd8,  1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110, 1'b0};
    localparam logic [20:0] E_AIEX   = {4'd9,  1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b010, 1'b0};
    localparam logic [20:0] E_AIWB   = {4'd10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};
    localparam logic [20:0] E_JMP    = {4'd11, 1'b0 | 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};
    localparam logic [20:0] E_ILL    = {4'd12, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1};

    localparam logic [5:0] R_FORM = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, ADDI = 6'h08, J = 6'h02;
    localparam logic [5:0] F_ADD = 6'h20;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    logic [20:0] exp_q[$];

    function automatic logic [20:0] dut_vec();
        return {STATE, PC_WE, PC_SRC, IORD, MEM_RE, MEM_WE, IR_WE, REG_WE, REG_DST, MEM_TO_REG,
                ALU_SRC_A, ALU_SRC_B, ALU_CTL, ILL_OP};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus with reset released; expected response goes to the scoreboard
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy,
                        input logic [20:0] exp);
        @(posedge CLK);
        #1;
        RST = 1'b1; Op = op; Funct = fn; Zero = z; MEM_RDY = rdy;
        exp_q.push_back(exp);
    endtask

    // Monitor: compare the presented outputs mid-cycle
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [20:0] e;
            e = exp_q.pop_front();
            cyc++;
            check($sformatf("cycle%0d", cyc), 32'(dut_vec()), 32'(e));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0; Op = 6'h00; Funct = 6'h00; Zero = 1'b0; MEM_RDY = 1'b1;
        repeat (2) begin
            @(posedge CLK);
            #1;
            exp_q.push_back(E_RST);
        end

        // R-format ADD
        step(R_FORM, F_ADD, 0, 1, E_FR);
        step(R_FORM, F_ADD, 0, 1, E_DEC);
        step(R_FORM, F_ADD, 0, 1, E_EXADD);
        step(R_FORM, F_ADD, 0, 1, E_AWB);
        // SW with two wait cycles in MEMWR
        step(SW, 0, 0, 1, E_FR);
        step(SW, 0, 0, 1, E_DEC);
        step(SW, 0, 0, 1, E_MADR);
        step(SW, 0, 0, 0, E_MWR);
        step(SW, 0, 0, 0, E_MWR);
        step(SW, 0, 0, 1, E_MWR);
        // LW with three stalled fetch cycles
        step(LW, 0, 0, 0, E_FW);
        step(LW, 0, 0, 0, E_FW);
        step(LW, 0, 0, 0, E_FW);
        step(LW, 0, 0, 1, E_FR);
        step(LW, 0, 0, 1, E_DEC);
        step(LW, 0, 0, 1, E_MADR);
        step(LW, 0, 0, 1, E_MRD);
        step(LW, 0, 0, 1, E_MWB);
        // BEQ taken, then not taken
        step(BEQ, 0, 1, 1, E_FR);
        step(BEQ, 0, 1, 1, E_DEC);
        step(BEQ, 0, 1, 1, E_BRZ1);
        step(BEQ, 0, 0, 1, E_FR);
        step(BEQ, 0, 0, 1, E_DEC);
        step(BEQ, 0, 0, 1, E_BRZ0);
        // ADDI and J
        step(ADDI, 0, 0, 1, E_FR);
        step(ADDI, 0, 0, 1, E_DEC);
        step(ADDI, 0, 0, 1, E_AIEX);
        step(ADDI, 0, 0, 1, E_AIWB);
        step(J, 0, 0, 1, E_FR);
        step(J, 0, 0, 1, E_DEC);
        step(J, 0, 0, 1, E_JMP);
        // Illegal opcode, then illegal function code
        step(6'h3F, 0, 0, 1, E_FR);
        step(6'h3F, 0, 0, 1, E_DEC);
        step(6'h3F, 0, 0, 1, E_ILL);
        step(R_FORM, 6'h3F, 0, 1, E_FR);
        step(R_FORM, 6'h3F, 0, 1, E_DEC);
        step(R_FORM, 6'h3F, 0, 1, E_EXBAD);
        step(R_FORM, 6'h3F, 0, 1, E_ILL);
        // LW stalled in MEMRD, then reset mid-cycle
        step(LW, 0, 0, 1, E_FR);
        step(LW, 0, 0, 1, E_DEC);
        step(LW, 0, 0, 1, E_MADR);
        step(LW, 0, 0, 0, E_MRD);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("async_rst_state", 32'(STATE), 32'd0);
        check("async_rst_mem_re", 32'(MEM_RE), 32'd0);
        check("async_rst_vec", 32'(dut_vec()), 32'(E_RST));
        @(posedge CLK);
        #1;
        exp_q.push_back(E_RST);
        // Clean instruction after release
        step(J, 0, 0, 1, E_FR);
        step(J, 0, 0, 1, E_DEC);
        step(J, 0, 0, 1, E_JMP);
        step(J, 0, 0, 0, E_FW);
        @(negedge CLK);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef CTRL_PERF_CNT_EN
        check("ret_cnt", RET_CNT, 32'd1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
